// File: rtl/adder_pipe_pkg.sv
// adder_pipe_pkg: shared op encodings and default geometry for the pipelined adder
package adder_pipe_pkg;
   localparam int DEF_WIDTH  = 16;
   localparam int DEF_STAGES = 4;
   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;
endpackage

// File: rtl/adder_pipe_stage.sv
// adder_pipe_stage: one CHUNK-bit slice of the ripple pipeline, registered token
module adder_pipe_stage #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4,
   parameter int IDX   = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             adv_i,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] s_i,
   input  logic             c_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic [WIDTH-1:0] s_o,
   output logic             c_o,
   output logic             ovf_o
);
   localparam int LO = IDX * CHUNK;
   localparam int HI = LO + CHUNK - 1;
   localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}}) << LO;

   logic [CHUNK:0]   sum;
   logic [WIDTH-1:0] s_d;
   logic             c_d;
   logic             ovf_d;
   logic             valid_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] s_q;
   logic             c_q;
   logic             ovf_q;

   assign sum   = {1'b0, a_i[LO +: CHUNK]} + {1'b0, b_i[LO +: CHUNK]} + {{CHUNK{1'b0}}, c_i};
   assign s_d   = (s_i & ~MASK) | (WIDTH'(sum[CHUNK-1:0]) << LO);
   assign c_d   = sum[CHUNK];
   // carry into the slice MSB is a^b^s at that bit; overflow when it differs from carry-out
   assign ovf_d = a_i[HI] ^ b_i[HI] ^ sum[CHUNK-1] ^ sum[CHUNK];

   // token register: the whole pipeline moves in lockstep on adv_i
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         c_q     <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (adv_i) begin
         valid_q <= valid_i;
         a_q     <= a_i;
         b_q     <= b_i;
         s_q     <= s_d;
         c_q     <= c_d;
         ovf_q   <= ovf_d;
      end
   end

   assign valid_o = valid_q;
   assign a_o     = a_q;
   assign b_o     = b_q;
   assign s_o     = s_q;
   assign c_o     = c_q;
   assign ovf_o   = ovf_q;
endmodule

// File: rtl/adder_pipe.sv
// adder_pipe: STAGES-deep slice-ripple add/sub pipeline with valid/ready handshake
module adder_pipe
   import adder_pipe_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             cout,
   output logic             ovf
);
   localparam int CHUNK = WIDTH / STAGES;

   if (WIDTH % STAGES != 0 || WIDTH < 4 || STAGES < 1 || STAGES > WIDTH) begin : g_bad_param
      $error("adder_pipe: WIDTH must be >= 4 and a multiple of STAGES (1..WIDTH)");
   end

   logic                        advance;
   logic                        sub;
   logic [STAGES:0]             v_w;
   logic [STAGES:0]             c_w;
   logic [STAGES:0][WIDTH-1:0]  a_w;
   logic [STAGES:0][WIDTH-1:0]  b_w;
   logic [STAGES:0][WIDTH-1:0]  s_w;
   logic [STAGES-1:0]           ovf_w;
   logic                        unused_w;

   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;
   assign sub      = op_e'(op) == OP_SUB;

   // subtraction is A + ~B + ~cin, so invert B and the borrow once at entry
   assign v_w[0] = in_valid;
   assign a_w[0] = A;
   assign b_w[0] = sub ? ~B : B;
   assign s_w[0] = '0;
   assign c_w[0] = sub ? ~cin : cin;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      adder_pipe_stage #(
         .WIDTH (WIDTH),
         .CHUNK (CHUNK),
         .IDX   (k)
      ) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .adv_i   (advance),
         .valid_i (v_w[k]),
         .a_i     (a_w[k]),
         .b_i     (b_w[k]),
         .s_i     (s_w[k]),
         .c_i     (c_w[k]),
         .valid_o (v_w[k+1]),
         .a_o     (a_w[k+1]),
         .b_o     (b_w[k+1]),
         .s_o     (s_w[k+1]),
         .c_o     (c_w[k+1]),
         .ovf_o   (ovf_w[k])
      );
   end

   assign out_valid = v_w[STAGES];
   assign S         = s_w[STAGES];
   assign cout      = c_w[STAGES];
   assign ovf       = ovf_w[STAGES-1];
   assign unused_w  = ^{a_w[STAGES], b_w[STAGES], ovf_w};
endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: directed and random scoreboard checks of the 16-bit, 4-stage adder pipe
module tb_adder_pipe;
   localparam int W = 16;
   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic          cin;
   logic          op;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  S;
   logic          cout;
   logic          ovf;

   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   int            nacc = 0;
   int            npop = 0;
   logic [W+1:0]  q[$];
   int            pop_cyc[$];

   adder_pipe #(.WIDTH(W), .STAGES(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .cin       (cin),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (S),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   function automatic logic [W+1:0] model(logic [W-1:0] a, logic [W-1:0] b, logic c, logic o);
      logic [W:0]   r;
      logic [W-1:0] s;
      logic         co;
      logic         v;
      if (!o) begin
         r  = {1'b0, a} + {1'b0, b} + (W+1)'(c);
         s  = r[W-1:0];
         co = r[W];
         v  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      end else begin
         s  = a - b - W'(c);
         co = {1'b0, a} >= ({1'b0, b} + (W+1)'(c));
         v  = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
      end
      return {s, co, v};
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // sample handshakes just after the falling edge, then advance one clock
   task automatic step();
      #1;
      if (in_valid && in_ready) begin
         q.push_back(model(A, B, cin, op));
         nacc++;
      end
      if (out_valid && out_ready) begin
         npop++;
         pop_cyc.push_back(cyc);
         chk("q_nonempty", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) chk("result", 32'({S, cout, ovf}), 32'(q.pop_front()));
      end
      cyc++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic rand_in();
      A   = W'($urandom);
      B   = W'($urandom);
      cin = 1'($urandom);
      op  = 1'($urandom);
   endtask

   task automatic directed(string tag, logic [W-1:0] a, logic [W-1:0] b, logic c, logic o,
                           logic [W-1:0] es, logic eco, logic ev);
      int n;
      A = a; B = b; cin = c; op = o; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_lat"}, 32'(n), 32'(N));
      chk({tag, "_S"}, 32'(S), 32'(es));
      chk({tag, "_cout"}, 32'(cout), 32'(eco));
      chk({tag, "_ovf"}, 32'(ovf), 32'(ev));
      step();
   endtask

   initial begin
      logic [W+2:0] snap;
      int           c0;
      int           p0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      A = '0; B = '0; cin = 1'b0; op = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_outs", 32'({S, cout, ovf}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      directed("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      directed("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      directed("sub_neg", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      directed("add_ovf", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
      directed("sub_borrow", 16'h0005, 16'h0004, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);

      // back-to-back burst of 8
      pop_cyc.delete();
      c0 = cyc;
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rand_in();
         step();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) step();
      chk("burst_count", 32'(pop_cyc.size()), 32'd8);
      if (pop_cyc.size() == 8) begin
         chk("burst_first", 32'(pop_cyc[0] - c0), 32'(N));
         chk("burst_span", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);
      end

      // fill then stall the consumer
      out_ready = 1'b0;
      in_valid = 1'b1;
      p0 = npop;
      for (int i = 0; i < 8; i++) begin
         rand_in();
         step();
      end
      #1;
      chk("stall_full", 32'(out_valid), 32'd1);
      snap = {out_valid, S, cout, ovf};
      for (int i = 0; i < 5; i++) begin
         rand_in();
         step();
         #1;
         chk("stall_ready", 32'(in_ready), 32'd0);
         chk("stall_hold", 32'({out_valid, S, cout, ovf}), 32'(snap));
      end
      out_ready = 1'b1;
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) step();
      chk("stall_delivered", 32'(npop - p0), 32'd4);
      chk("stall_drained", 32'(q.size()), 32'd0);

      // reset with tokens in flight
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_in();
         step();
      end
      in_valid = 1'b0;
      step();
      chk("flight_valid", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_clear", 32'(out_valid), 32'd0);
      chk("async_outs", 32'({S, cout, ovf}), 32'd0);
      chk("async_ready", 32'(in_ready), 32'd1);
      q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      p0 = npop;
      for (int i = 0; i < 8; i++) step();
      chk("no_stale", 32'(npop - p0), 32'd0);

      // random regression with random valid/ready
      c0 = nacc;
      for (int i = 0; i < 20000 && nacc - c0 < 3000; i++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         rand_in();
         step();
      end
      chk("rand_accepted", 32'(nacc - c0 >= 3000), 32'd1);
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) step();
      chk("rand_drained", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
